// File: rtl/record_mode_pkg.sv
// Shared widths, FSM state type and track-entry layout for the record path.
// Entries use the song-table encoding {octave[10:8], note[7:5], pad[4], length[3:0]}.
package record_mode_pkg;

    localparam int OCT_W     = 3;
    localparam int NOTE_W    = 3;
    localparam int LEN_W     = 4;
    localparam int KEY_W     = 7;
    localparam int ENTRY_W   = 11;
    localparam int NOTE_REST = 0;
    localparam int LEN_MAX   = 15;

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef struct packed {
        logic [OCT_W-1:0]  octave;
        logic [NOTE_W-1:0] note;
        logic [LEN_W-1:0]  length;
    } entry_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_NOTE,
        ST_GAP,
        ST_FULL
    } rec_state_t;

    function automatic entry_t pack_entry(input logic [OCT_W-1:0] octave,
                                          input logic [NOTE_W-1:0] note,
                                          input logic [LEN_W-1:0] length);
        return {octave, note, 1'b0, length};
    endfunction

    function automatic entry_fields_t unpack_entry(input entry_t e);
        entry_fields_t f;
        f.octave = e[10:8];
        f.note   = e[7:5];
        f.length = e[3:0];
        return f;
    endfunction

    // Lowest pressed key wins; 0 means all keys released.
    function automatic logic [NOTE_W-1:0] key_decode(input logic [KEY_W-1:0] k);
        logic [NOTE_W-1:0] n;
        n = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (k[i]) n = NOTE_W'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [KEY_W-1:0] note_to_led(input logic [NOTE_W-1:0] n);
        logic [KEY_W-1:0] led;
        led = '0;
        if (n != '0) led = KEY_W'(1) << (n - NOTE_W'(1));
        return led;
    endfunction

endpackage

// File: rtl/record_mode_if.sv
// Player controls, status and track read port of the recorder, grouped as one bus.
interface record_mode_if #(
    parameter int ADDR_W = 6
);
    logic              en;
    logic              oct_up;
    logic              oct_down;
    logic [6:0]        note_key;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        rd_octave;
    logic [2:0]        rd_note;
    logic [3:0]        rd_length;
    logic [ADDR_W:0]   track_len;
    logic              recording;
    logic              full;
    logic [2:0]        cur_octave;
    logic [6:0]        note_led;

    modport master (
        output en, oct_up, oct_down, note_key, rd_addr,
        input  rd_octave, rd_note, rd_length, track_len, recording, full,
               cur_octave, note_led
    );

    modport slave (
        input  en, oct_up, oct_down, note_key, rd_addr,
        output rd_octave, rd_note, rd_length, track_len, recording, full,
               cur_octave, note_led
    );
endinterface

// File: rtl/record_mode_track_ram.sv
// Single-write, single synchronous-read track RAM; a same-address read returns old data.
module track_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/record_mode.sv
// Key/octave capture FSM: times held notes and gaps and writes {octave, note, length}
// entries into track_ram, which a replay or scoring engine reads back by index.
module record_mode
    import record_mode_pkg::*;
#(
    parameter int CLK_PER_TICK  = 100000,
    parameter int TICK_PER_UNIT = 125,
    parameter int DEPTH         = 64,
    parameter int ADDR_W        = 6,
    parameter int OCT_MIN       = 1,
    parameter int OCT_MAX       = 7,
    parameter int OCT_INIT      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    record_mode_if.slave bus
);

    localparam int TICK_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam int SUB_W  = (TICK_PER_UNIT > 1) ? $clog2(TICK_PER_UNIT) : 1;

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] u);
        return (u == LEN_W'(LEN_MAX)) ? u : u + LEN_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] u);
        return (u == '0) ? LEN_W'(1) : u;
    endfunction

    logic en_m, en_s, en_d, up_m, up_s, up_d, dn_m, dn_s, dn_d;
    logic [KEY_W-1:0] key_m, key_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {en_m, en_s, en_d} <= '0;
            {up_m, up_s, up_d} <= '0;
            {dn_m, dn_s, dn_d} <= '0;
            key_m <= '0;
            key_s <= '0;
        end else begin
            {en_m, en_s, en_d} <= {bus.en, en_m, en_s};
            {up_m, up_s, up_d} <= {bus.oct_up, up_m, up_s};
            {dn_m, dn_s, dn_d} <= {bus.oct_down, dn_m, dn_s};
            key_m <= bus.note_key;
            key_s <= key_m;
        end
    end

    logic en_rise, up_rise, dn_rise;
    logic [NOTE_W-1:0] key_note;
    assign en_rise  = en_s & ~en_d;
    assign up_rise  = up_s & ~up_d;
    assign dn_rise  = dn_s & ~dn_d;
    assign key_note = key_decode(key_s);

    rec_state_t        state, state_nxt;
    logic [ADDR_W:0]   track_len;
    logic [OCT_W-1:0]  cur_oct, lat_oct;
    logic [NOTE_W-1:0] lat_note;
    logic [TICK_W-1:0] tick_cnt;
    logic [SUB_W-1:0]  sub_cnt;
    logic [LEN_W-1:0]  units;
    logic              clr_tmr, latch, wr_en, len_rst;
    entry_t            wr_entry, rd_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sub_cnt  <= '0;
            units    <= '0;
        end else if (clr_tmr) begin
            tick_cnt <= '0;
            sub_cnt  <= '0;
            units    <= '0;
        end else if (tick_cnt == TICK_W'(CLK_PER_TICK - 1)) begin
            tick_cnt <= '0;
            if (sub_cnt == SUB_W'(TICK_PER_UNIT - 1)) begin
                sub_cnt <= '0;
                units   <= sat_inc(units);
            end else begin
                sub_cnt <= sub_cnt + SUB_W'(1);
            end
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Simultaneous up and down edges cancel; the octave is frozen while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_oct <= OCT_W'(OCT_INIT);
        end else if (len_rst) begin
            cur_oct <= OCT_W'(OCT_INIT);
        end else if (state != ST_IDLE) begin
            if (up_rise && !dn_rise && cur_oct < OCT_W'(OCT_MAX))
                cur_oct <= cur_oct + OCT_W'(1);
            else if (dn_rise && !up_rise && cur_oct > OCT_W'(OCT_MIN))
                cur_oct <= cur_oct - OCT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            track_len <= '0;
        end else begin
            state <= state_nxt;
            if (len_rst)    track_len <= '0;
            else if (wr_en) track_len <= track_len + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            lat_note <= key_note;
            lat_oct  <= cur_oct;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_entry  = '0;
        clr_tmr   = 1'b0;
        latch     = 1'b0;
        len_rst   = 1'b0;
        if (!en_s) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (en_rise) begin
                    len_rst   = 1'b1;
                    state_nxt = ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: if (key_note != '0) begin
                    latch     = 1'b1;
                    clr_tmr   = 1'b1;
                    state_nxt = ST_NOTE;
                end
                ST_NOTE: if (key_note != lat_note) begin
                    wr_en     = 1'b1;
                    wr_entry  = pack_entry(lat_oct, lat_note, clamp_len(units));
                    clr_tmr   = 1'b1;
                    latch     = (key_note != '0);
                    state_nxt = (key_note == '0) ? ST_GAP : ST_NOTE;
                end
                ST_GAP: if (key_note != '0) begin
                    wr_en     = (units != '0);
                    wr_entry  = pack_entry(cur_oct, NOTE_W'(NOTE_REST), clamp_len(units));
                    latch     = 1'b1;
                    clr_tmr   = 1'b1;
                    state_nxt = ST_NOTE;
                end
                default: ;
            endcase
            if (wr_en && track_len == (ADDR_W+1)'(DEPTH - 1)) state_nxt = ST_FULL;
        end
    end

    track_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_track_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_en),
        .wr_addr (track_len[ADDR_W-1:0]),
        .wr_data (wr_entry),
        .rd_addr (bus.rd_addr),
        .rd_data (rd_entry)
    );

    entry_fields_t rd_fields;
    assign rd_fields      = unpack_entry(rd_entry);
    assign bus.rd_octave  = rd_fields.octave;
    assign bus.rd_note    = rd_fields.note;
    assign bus.rd_length  = rd_fields.length;
    assign bus.track_len  = track_len;
    assign bus.recording  = (state == ST_WAIT_FIRST) || (state == ST_NOTE) || (state == ST_GAP);
    assign bus.full       = (state == ST_FULL);
    assign bus.cur_octave = cur_oct;
    assign bus.note_led   = (state == ST_NOTE) ? note_to_led(lat_note) : '0;

endmodule
